// File: rtl/lnvd_adc_pkg.sv
// Shared types and constants for the ADC responder stand-in.
// Covers channel/data widths, FSM states, pattern modes and LFSR parameters.
package lnvd_adc_pkg;

    localparam int ADC_CH_W   = 5;
    localparam int ADC_DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        RESPOND = 2'd2
    } adc_state_e;

    localparam logic [1:0] PAT_RAMP     = 2'd0;
    localparam logic [1:0] PAT_TAG      = 2'd1;
    localparam logic [1:0] PAT_LFSR     = 2'd2;
    localparam logic [1:0] PAT_RAMP_ALT = 2'd3;

    // Fibonacci taps for x^12 + x^6 + x^4 + x + 1
    localparam logic [ADC_DATA_W-1:0] LFSR_SEED = 12'hACE;
    localparam logic [ADC_DATA_W-1:0] LFSR_TAPS = 12'h829;

    function automatic logic [ADC_DATA_W-1:0] lfsr_next(input logic [ADC_DATA_W-1:0] v);
        return {v[ADC_DATA_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lnvd_adc_pattern_gen.sv
// Deterministic sample source: per-channel ramps, response sequence tag and LFSR.
// data is combinational for the current state; advance commits one response.
module lnvd_adc_pattern_gen
    import lnvd_adc_pkg::*;
#(
    parameter int                     NUM_CH    = 9,
    parameter logic [ADC_DATA_W-1:0]  RAMP_STEP = 12'd1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    advance,
    input  logic [ADC_CH_W-1:0]     channel,
    input  logic [1:0]              mode,
    output logic [ADC_DATA_W-1:0]   data
);

    logic [ADC_DATA_W-1:0] ramp_r [NUM_CH];
    logic [7:0]            seq_r;
    logic [ADC_DATA_W-1:0] lfsr_r;
    logic [ADC_DATA_W-1:0] ramp_sel_s;
    logic                  in_range_s;
    logic                  is_ramp_s;

    // Channel range check and ramp selection without out-of-range indexing
    always_comb begin
        in_range_s = (channel < ADC_CH_W'(NUM_CH));
        is_ramp_s  = (mode == PAT_RAMP) || (mode == PAT_RAMP_ALT);
        ramp_sel_s = 12'h000;
        for (int i = 0; i < NUM_CH; i++) begin
            ramp_sel_s = ramp_sel_s | ((channel == ADC_CH_W'(i)) ? ramp_r[i] : 12'h000);
        end
    end

    // Sample value for the latched channel and mode
    always_comb begin
        data = 12'h000;
        if (!in_range_s) begin
            data = 12'h000;
        end else begin
            case (mode)
                PAT_TAG:      data = {channel[3:0], seq_r};
                PAT_LFSR:     data = lfsr_r;
                PAT_RAMP:     data = ramp_sel_s;
                PAT_RAMP_ALT: data = ramp_sel_s;
                default:      data = ramp_sel_s;
            endcase
        end
    end

    // Pattern state update on each issued response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ramp_r[i] <= 12'h000;
            end
            seq_r  <= 8'd0;
            lfsr_r <= LFSR_SEED;
        end else if (advance) begin
            seq_r <= seq_r + 8'd1;
            if (mode == PAT_LFSR) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_range_s && is_ramp_s && (channel == ADC_CH_W'(i))) begin
                    ramp_r[i] <= ramp_r[i] + RAMP_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/lnvd_adc_responder.sv
// Responder side of the ADC command/response interface: one command in,
// one response out after a fixed conversion time, with pattern data.
module lnvd_adc_responder
    import lnvd_adc_pkg::*;
#(
    parameter int                     CONV_CYCLES = 50,
    parameter int                     NUM_CH      = 9,
    parameter logic [ADC_DATA_W-1:0]  RAMP_STEP   = 12'd1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADC_CH_W-1:0]     cmd_channel,
    input  logic                    cmd_sop,
    input  logic                    cmd_eop,
    input  logic [1:0]              pattern_sel,
    output logic                    rsp_valid,
    output logic [ADC_CH_W-1:0]     rsp_channel,
    output logic [ADC_DATA_W-1:0]   rsp_data,
    output logic                    rsp_sop,
    output logic                    rsp_eop,
    output logic                    busy
);

    localparam int               CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 2);

    adc_state_e            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADC_CH_W-1:0]   ch_r;
    logic [1:0]            mode_r;
    logic                  sop_r;
    logic                  eop_r;
    logic                  cmd_ready_r;
    logic                  rsp_valid_r;
    logic [ADC_CH_W-1:0]   rsp_channel_r;
    logic [ADC_DATA_W-1:0] rsp_data_r;
    logic                  rsp_sop_r;
    logic                  rsp_eop_r;
    logic                  busy_r;
    logic                  accept_s;
    logic                  advance_s;
    logic [ADC_DATA_W-1:0] pat_data_s;

    assign accept_s  = cmd_valid & cmd_ready_r;
    assign advance_s = (state_r == CONVERT) && (cnt_r == '0);

    lnvd_adc_pattern_gen #(
        .NUM_CH    (NUM_CH),
        .RAMP_STEP (RAMP_STEP)
    ) u_pattern_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance_s),
        .channel (ch_r),
        .mode    (mode_r),
        .data    (pat_data_s)
    );

    // Command/convert/respond sequencing with registered handshake and response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            ch_r          <= 5'd0;
            mode_r        <= PAT_RAMP;
            sop_r         <= 1'b0;
            eop_r         <= 1'b0;
            cmd_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_channel_r <= 5'd0;
            rsp_data_r    <= 12'h000;
            rsp_sop_r     <= 1'b0;
            rsp_eop_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE, RESPOND: begin
                    if (accept_s) begin
                        ch_r        <= cmd_channel;
                        mode_r      <= pattern_sel;
                        sop_r       <= cmd_sop;
                        eop_r       <= cmd_eop;
                        cnt_r       <= CNT_LOAD;
                        state_r     <= CONVERT;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (cnt_r == '0) begin
                        state_r       <= RESPOND;
                        rsp_valid_r   <= 1'b1;
                        rsp_channel_r <= ch_r;
                        rsp_data_r    <= pat_data_s;
                        rsp_sop_r     <= sop_r;
                        rsp_eop_r     <= eop_r;
                        cmd_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_channel = rsp_channel_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_sop     = rsp_sop_r;
    assign rsp_eop     = rsp_eop_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_lnvd_adc_responder.sv
// Randomized self-checking bench for lnvd_adc_responder against a behavioural model.
module tb_lnvd_adc_responder;

    localparam int CONV = 50;
    localparam int NCH  = 9;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_sop, cmd_eop;
    logic [4:0]  cmd_channel;
    logic [1:0]  pattern_sel;
    logic        rsp_valid, rsp_sop, rsp_eop, busy;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;

    logic        w_cmd_valid, w_cmd_ready, w_rsp_valid, w_rsp_sop, w_rsp_eop, w_busy;
    logic [4:0]  w_rsp_channel;
    logic [11:0] w_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ramp[32];
    int m_seq;
    int m_lfsr;
    int last_data;
    int last_ch;
    int w_lat;
    int seen;
    int wrap_exp[3];

    always #10 clk = ~clk;

    lnvd_adc_responder #(.CONV_CYCLES(CONV), .NUM_CH(NCH), .RAMP_STEP(12'd1)) u_dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
        .pattern_sel(pattern_sel), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel),
        .rsp_data(rsp_data), .rsp_sop(rsp_sop), .rsp_eop(rsp_eop), .busy(busy)
    );

    lnvd_adc_responder #(.CONV_CYCLES(2), .NUM_CH(NCH), .RAMP_STEP(12'h800)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .cmd_valid(w_cmd_valid), .cmd_ready(w_cmd_ready),
        .cmd_channel(5'd1), .cmd_sop(1'b0), .cmd_eop(1'b0),
        .pattern_sel(2'd0), .rsp_valid(w_rsp_valid), .rsp_channel(w_rsp_channel),
        .rsp_data(w_rsp_data), .rsp_sop(w_rsp_sop), .rsp_eop(w_rsp_eop), .busy(w_busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ramp[i] = 0;
        m_seq     = 0;
        m_lfsr    = 32'hACE;
        last_data = 0;
        last_ch   = 0;
    endtask

    // One step of x^12+x^6+x^4+x+1: feedback from stages 12, 6, 4 and 1
    function automatic int lfsr_step(input int v);
        int fb;
        fb = ((v >> 11) ^ (v >> 5) ^ (v >> 3) ^ v) & 1;
        return ((v << 1) & 32'hFFF) | fb;
    endfunction

    task automatic model_predict(input int ch, input int mode, output int data);
        if (ch >= NCH)      data = 0;
        else if (mode == 1) data = (ch % 16) * 256 + m_seq;
        else if (mode == 2) data = m_lfsr;
        else                data = m_ramp[ch];
        if (ch < NCH && (mode == 0 || mode == 3)) m_ramp[ch] = (m_ramp[ch] + STEP) % 4096;
        if (mode == 2) m_lfsr = lfsr_step(m_lfsr);
        m_seq = (m_seq + 1) % 256;
    endtask

    // Issue one command at the current negedge and check its response.
    task automatic run_one(input int ch, input int mode, input int sop, input int eop, input int b2b_next);
        int exp_d, lat, rdy_hi, busy_lo;
        cmd_channel = 5'(ch);
        pattern_sel = 2'(mode);
        cmd_sop     = 1'(sop);
        cmd_eop     = 1'(eop);
        cmd_valid   = 1'b1;
        chk_eq("acc_ready", cmd_ready, 1);
        model_predict(ch, mode, exp_d);
        @(negedge clk);
        if (b2b_next == 0) cmd_valid = 1'b0;
        chk_eq("rsp_pulse", rsp_valid, 0);
        chk_eq("rsp_hold", rsp_data, last_data);
        lat = 1; rdy_hi = 0; busy_lo = 0;
        while (!rsp_valid && lat < CONV + 5) begin
            if (cmd_ready) rdy_hi++;
            if (!busy) busy_lo++;
            pattern_sel = 2'($urandom_range(0, 3));
            cmd_channel = 5'($urandom_range(0, 31));
            @(negedge clk);
            lat++;
        end
        chk_eq("latency", lat, CONV);
        chk_eq("conv_ready_low", rdy_hi, 0);
        chk_eq("conv_busy_high", busy_lo, 0);
        chk_eq("rsp_busy", busy, 0);
        chk_eq("rsp_channel", rsp_channel, ch);
        chk_eq("rsp_data", rsp_data, exp_d);
        chk_eq("rsp_sop", rsp_sop, sop);
        chk_eq("rsp_eop", rsp_eop, eop);
        last_data = exp_d;
        last_ch   = ch;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_channel = 5'd0; cmd_sop = 1'b0;
        cmd_eop = 1'b0; pattern_sel = 2'd0; w_cmd_valid = 1'b0;
        wrap_exp[0] = 32'h000; wrap_exp[1] = 32'h800; wrap_exp[2] = 32'h000;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_eq("rst_ready", cmd_ready, 1);
        chk_eq("rst_valid", rsp_valid, 0);
        chk_eq("rst_channel", rsp_channel, 0);
        chk_eq("rst_data", rsp_data, 0);
        chk_eq("rst_sopeop", {rsp_sop, rsp_eop}, 0);
        chk_eq("rst_busy", busy, 0);

        // Ramp wrap with a half-range step on a short-conversion instance
        for (int k = 0; k < 3; k++) begin
            w_cmd_valid = 1'b1;
            chk_eq("wrap_ready", w_cmd_ready, 1);
            @(negedge clk);
            w_cmd_valid = 1'b0;
            w_lat = 1;
            while (!w_rsp_valid && w_lat < 10) begin
                @(negedge clk);
                w_lat++;
            end
            chk_eq("wrap_lat", w_lat, 2);
            chk_eq("wrap_data", w_rsp_data, wrap_exp[k]);
        end

        run_one(3, 0, 1, 1, 0);
        chk_eq("first_data", rsp_data, 12'h000);
        repeat (3) @(negedge clk);

        // Continuous valid, rotating channels, ramp mode
        for (int k = 0; k < 8; k++) run_one(1 + k % 4, 0, k == 0, k == 7, k != 7);

        for (int k = 0; k < 4; k++) begin
            run_one(0, 2, 1, 1, k != 3);
            if (k == 0) chk_eq("lfsr_seed", rsp_data, 12'hACE);
            chk_eq("lfsr_nonzero", rsp_data != 12'h000, 1);
        end

        run_one(20, 0, 0, 1, 1);
        chk_eq("oor_data", rsp_data, 12'h000);
        run_one(1, 0, 0, 0, 0);

        while (m_seq != 255)
            run_one($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
        run_one(5, 1, 1, 1, 1);
        chk_eq("tag_5ff", rsp_data, 12'h5FF);
        run_one(5, 1, 1, 0, 0);
        chk_eq("tag_500", rsp_data, 12'h500);
        repeat (2) @(negedge clk);

        // Abort a conversion with reset in its 20th cycle
        cmd_channel = 5'd3; pattern_sel = 2'd0; cmd_sop = 1'b1; cmd_eop = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk_eq("abort_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk_eq("abort_rst_ready", cmd_ready, 1);
        chk_eq("abort_rst_busy", busy, 0);
        chk_eq("abort_rst_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (CONV + 10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk_eq("abort_no_rsp", seen, 0);
        run_one(3, 0, 1, 1, 1);
        chk_eq("post_rst_ramp", rsp_data, 12'h000);
        run_one(0, 2, 0, 0, 0);
        chk_eq("post_rst_lfsr", rsp_data, 12'hACE);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
